// File: rtl/sd_spi_if.sv
// IO-bus side of the SD SPI peripheral: register index, strobes, data and interrupt.
// Strobes are single-cycle and always accepted (no back-pressure); io_rdata is combinational on io_addr.
interface sd_spi_if;
    logic [3:0] io_addr;
    logic       io_write;
    logic       io_read;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       interrupt;

    modport master (
        output io_addr, io_write, io_read, io_wdata,
        input  io_rdata, interrupt
    );

    modport slave (
        input  io_addr, io_write, io_read, io_wdata,
        output io_rdata, interrupt
    );
endinterface

// File: rtl/sd_spi.sv
// SPI mode-0 master for an SD card: 8-bit MSB-first transfers, programmable SCLK divider,
// software-driven chip select, level interrupt on transfer done.
module sd_spi #(
    parameter int                DIV_W     = 8,
    parameter logic [DIV_W-1:0]  DIV_RESET = DIV_W'(63)
) (
    input  logic       clk,
    input  logic       reset,
    sd_spi_if.slave    bus,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       txsr_q, txsr_d;
    logic [7:0]       rxsr_q, rxsr_d;
    logic [7:0]       rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             ie_q, ie_d;
    logic             cs_q, cs_d;

    logic busy;
    logic wr_data, wr_status, wr_ctrl, wr_div, rd_data;

    assign busy      = (state_q != IDLE);
    assign wr_data   = bus.io_write && (bus.io_addr == 4'd0);
    assign wr_status = bus.io_write && (bus.io_addr == 4'd1);
    assign wr_ctrl   = bus.io_write && (bus.io_addr == 4'd2);
    assign wr_div    = bus.io_write && (bus.io_addr == 4'd3);
    assign rd_data   = bus.io_read  && (bus.io_addr == 4'd0);

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        div_d   = div_q;
        bcnt_d  = bcnt_q;
        txsr_d  = txsr_q;
        rxsr_d  = rxsr_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        cs_d    = cs_q;

        // Clear-on-read comes first so a completion in the same cycle overrides it.
        if (rd_data) begin
            done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (wr_data) begin
                    txsr_d  = bus.io_wdata;
                    mosi_d  = bus.io_wdata[7];
                    bcnt_d  = 3'd0;
                    dcnt_d  = div_q;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - DIV_W'(1);
                end else begin
                    sclk_d  = 1'b1;
                    rxsr_d  = {rxsr_q[6:0], miso};
                    dcnt_d  = div_q;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - DIV_W'(1);
                end else begin
                    sclk_d = 1'b0;
                    if (bcnt_q == 3'd7) begin
                        rx_d    = rxsr_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        txsr_d  = {txsr_q[6:0], 1'b0};
                        mosi_d  = txsr_q[6];
                        bcnt_d  = bcnt_q + 3'd1;
                        dcnt_d  = div_q;
                        state_d = LOW;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start request while a byte is in flight (including its final cycle) is dropped.
        if (wr_data && busy) begin
            ovr_d = 1'b1;
        end
        if (wr_status && bus.io_wdata[3]) begin
            ovr_d = 1'b0;
        end
        if (wr_ctrl) begin
            cs_d = bus.io_wdata[0];
            ie_d = bus.io_wdata[1];
        end
        if (wr_div && !busy) begin
            div_d = bus.io_wdata[DIV_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            div_q   <= DIV_RESET;
            bcnt_q  <= 3'd0;
            txsr_q  <= 8'h00;
            rxsr_q  <= 8'h00;
            rx_q    <= 8'hFF;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            txsr_q  <= txsr_d;
            rxsr_q  <= rxsr_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        bus.io_rdata = 8'h00;
        case (bus.io_addr)
            4'd0:    bus.io_rdata = rx_q;
            4'd1:    bus.io_rdata = {4'b0000, ovr_q, ie_q, done_q, busy};
            4'd2:    bus.io_rdata = {6'b000000, ie_q, cs_q};
            4'd3:    bus.io_rdata = 8'(div_q);
            default: bus.io_rdata = 8'h00;
        endcase
    end

    assign bus.interrupt = done_q & ie_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign cs_n          = ~cs_q;
    assign dbg_state     = state_q;
endmodule
